onehot_rr_arbiter: RTL
======================

// Module: onehot_rr_arbiter
// PURPOSE
//   Round-robin arbiter producing the one-hot select that drives onehot_mux.
//   N requesters compete. One winner is presented downstream with a valid/ready handshake.
//   The grant is held stable across downstream stalls, so the mux output cannot change mid-transfer.
//   A binary index of the winner is also provided for tagging and debug.
// PARAMETERS
//   N      4               number of requesters (>=2); equals the onehot_mux SEL_WIDTH
//   IDX_W  $clog2(N)       width of gnt_idx_o (localparam, derived)
// PORTS
//   clk_i      in   1      clock, rising edge
//   rst_ni     in   1      asynchronous reset, active-low
//   req_i      in   N      request vector; bit i = requester i has data
//   ready_i    in   1      downstream accepts the current grant this cycle
//   valid_o    out  1      a grant is being presented
//   gnt_oh_o   out  N      one-hot grant (all-zero when valid_o=0); feeds onehot_mux sel_oh_i
//   gnt_idx_o  out  IDX_W  binary index of the granted requester (0 when valid_o=0)
//   lock_i     in   1      only present when RR_ARB_LOCK_EN is defined
// BEHAVIOUR
//   State
//   - ptr_q [IDX_W]: index of the highest-priority requester.
//   - hold_q [1]: a grant is stalled and must be kept.
//   - hgnt_q [N]: the held grant.
//   Reset (rst_ni=0, asynchronous)
//   - ptr_q=0, hold_q=0, hgnt_q=0.
//   - Outputs are then purely a function of req_i; with req_i=0: valid_o=0, gnt_oh_o=0, gnt_idx_o=0.
//   Arbitration when hold_q=0 (combinational, zero latency)
//   - Winner = first set bit of req_i found searching ptr_q, ptr_q+1, ... N-1, then wrapping to 0.
//   - valid_o = |req_i.
//   - gnt_oh_o = one-hot of the winner.
//   Arbitration when hold_q=1
//   - gnt_oh_o=hgnt_q and valid_o=1, regardless of req_i.
//   - New or higher-priority requests are ignored until the handshake completes.
//   Handshake (valid_o & ready_i)
//   - Transfer completes. ptr_q <= (winner+1) mod N, wrapping from N-1 to 0.
//   - hold_q <= 0.
//   Stall (valid_o & ~ready_i)
//   - hold_q <= 1, hgnt_q <= gnt_oh_o.
//   - ptr_q is unchanged.
//   No request (valid_o=0)
//   - All state is unchanged.
//   Requester protocol
//   - Once requester i is granted, it keeps req_i[i]=1 until the handshake.
//   - Dropping req_i[i] while held is a protocol error: the grant is still presented.
//   Invariants
//   - gnt_oh_o is $onehot0 in every cycle.
//   - gnt_oh_o is nonzero iff valid_o=1.
//   - A requester that stays asserted is granted within N handshakes (no starvation).
//   Under COMM_ASSERT
//   - Assert $onehot0(gnt_oh_o).
//   - Assert that a held grant's request bit stays set.
// CONFIGURATION
//   RR_ARB_LOCK_EN defined
//   - Adds input lock_i.
//   - When a handshake occurs with lock_i=1, ptr_q <= winner instead of winner+1.
//   - The same requester therefore keeps top priority, for multi-beat bursts.
//   - lock_i is ignored on cycles with no handshake.
//   - If the locked requester drops req_i, normal round-robin search resumes from its index.
//   RR_ARB_LOCK_EN undefined
//   - No lock_i port; ptr_q always advances to winner+1.
// TESTING (N=4)
//   1. After reset, req_i=4'b1111, ready_i=1 every cycle
//      -> gnt_oh_o = 0001, 0010, 0100, 1000, 0001; gnt_idx_o = 0, 1, 2, 3, 0.
//   2. req_i=4'b0101, ready_i=0 for 3 cycles, then 1
//      -> gnt_oh_o=0001 for all 4 cycles, valid_o=1; the cycle after the handshake gives gnt 0100.
//   3. Held gnt 0100 with ready_i=0, then req_i changes 0100 -> 0110 -> 0111
//      -> gnt stays 0100 until ready_i=1; the next grant is 0001 (search starts at 3 and wraps).
//   4. Wrap: grant 1000 handshakes, then req_i=1001
//      -> gnt 0001; then req_i=0000 -> valid_o=0, gnt_oh_o=0000, gnt_idx_o=0.
//   5. Held gnt 0010, rst_ni pulsed low mid-stall, req_i=1111
//      -> outputs immediately follow ptr=0: gnt 0001; hold is cleared.
//   6. RR_ARB_LOCK_EN: req_i=1111, handshake on gnt 0100 with lock_i=1
//      -> next gnt 0100; handshake with lock_i=0 -> next gnt 1000.

Source files
------------

// File: rtl/onehot_rr_arbiter_if.sv
// Handshake bundle between requesters, onehot_rr_arbiter and the downstream onehot_mux.
// lock_i exists only when RR_ARB_LOCK_EN is defined.
interface onehot_rr_arbiter_if #(
  parameter int N = 4
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]     req_i;
  logic             ready_i;
  logic             valid_o;
  logic [N-1:0]     gnt_oh_o;
  logic [IDX_W-1:0] gnt_idx_o;
`ifdef RR_ARB_LOCK_EN
  logic             lock_i;

  modport master (output req_i, ready_i, lock_i, input valid_o, gnt_oh_o, gnt_idx_o);
  modport slave  (input req_i, ready_i, lock_i, output valid_o, gnt_oh_o, gnt_idx_o);
`else
  modport master (output req_i, ready_i, input valid_o, gnt_oh_o, gnt_idx_o);
  modport slave  (input req_i, ready_i, output valid_o, gnt_oh_o, gnt_idx_o);
`endif
endinterface

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with a grant held stable across downstream stalls.
// Optional burst lock via RR_ARB_LOCK_EN; assertions via COMM_ASSERT.
module onehot_rr_arbiter #(
  parameter int N = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  onehot_rr_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N);

  typedef enum logic {ARB, HELD} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     hgnt_q, hgnt_d;

  logic [N-1:0]     arb_oh;
  logic [IDX_W:0]   cand;
  logic             found;
  logic [N-1:0]     gnt_oh;
  logic [IDX_W-1:0] win_idx;
  logic             valid;
  logic             lock;

`ifdef RR_ARB_LOCK_EN
  assign lock = bus.lock_i;
`else
  assign lock = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB;
      ptr_q   <= '0;
      hgnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hgnt_q  <= hgnt_d;
    end
  end

  // Rotating priority search: candidates ptr_q, ptr_q+1, ... taken modulo N.
  always_comb begin
    arb_oh = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!found && bus.req_i[cand[IDX_W-1:0]]) begin
        arb_oh[cand[IDX_W-1:0]] = 1'b1;
        found                   = 1'b1;
      end
    end
  end

  always_comb begin
    valid   = (state_q == HELD) || (|bus.req_i);
    gnt_oh  = (state_q == HELD) ? hgnt_q : arb_oh;
    win_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_oh[i]) win_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hgnt_d  = hgnt_q;
    if (valid) begin
      if (bus.ready_i) begin
        state_d = ARB;
        ptr_d   = lock ? win_idx
                       : ((win_idx == IDX_W'(N-1)) ? '0 : win_idx + 1'b1);
      end else begin
        state_d = HELD;
        hgnt_d  = gnt_oh;
      end
    end
  end

  assign bus.valid_o   = valid;
  assign bus.gnt_oh_o  = gnt_oh;
  assign bus.gnt_idx_o = win_idx;

`ifdef COMM_ASSERT
  a_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(bus.gnt_oh_o));
  a_held_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == HELD) |-> |(bus.req_i & hgnt_q));
`endif
endmodule
